// File: rtl/cache_fill_if.sv
// Handshake bundle between the cache miss controller, main memory and the
// cache data/tag arrays. The master side is the fill controller.
interface cache_fill_if;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        mem_read;
    logic [15:0] mem_address;
    logic        mem_data_valid;
    logic [15:0] mem_data;
    logic        write_data_array;
    logic [7:0]  word_enable;
    logic [15:0] fill_data;
    logic        write_tag_array;

    modport master (
        input  miss_detected,
        input  miss_address,
        input  mem_data_valid,
        input  mem_data,
        output fsm_busy,
        output mem_read,
        output mem_address,
        output write_data_array,
        output word_enable,
        output fill_data,
        output write_tag_array
    );

    modport slave (
        output miss_detected,
        output miss_address,
        output mem_data_valid,
        output mem_data,
        input  fsm_busy,
        input  mem_read,
        input  mem_address,
        input  write_data_array,
        input  word_enable,
        input  fill_data,
        input  write_tag_array
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: issues eight pipelined word reads for the
// 16-byte block of a missing address, steers returned words into the data
// array one-hot, then pulses a single tag-array write to validate the block.
module cache_fill_fsm (
    input  logic          clk,
    input  logic          rst,
    cache_fill_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [2:0]  req_cnt_q, req_cnt_d;
    logic        req_done_q, req_done_d;
    logic [2:0]  rcv_cnt_q, rcv_cnt_d;
    logic        rcv_done_q, rcv_done_d;

    logic        fsm_busy_q, fsm_busy_d;
    logic        mem_read_q, mem_read_d;
    logic [15:0] mem_address_q, mem_address_d;
    logic        write_tag_q, write_tag_d;

    logic        accept_s;
    logic [7:0]  word_enable_s;

    // Data path: a returning word is written only while filling and only
    // until the eighth word has been taken; fill_data is a plain pass.
    always_comb begin
        accept_s      = 1'b0;
        word_enable_s = 8'h00;
        if ((state_q == FILL) && bus.mem_data_valid && !rcv_done_q) begin
            accept_s      = 1'b1;
            word_enable_s = 8'h01 << rcv_cnt_q;
        end else begin
            accept_s      = 1'b0;
            word_enable_s = 8'h00;
        end
    end

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        req_cnt_d  = req_cnt_q;
        req_done_d = req_done_q;
        rcv_cnt_d  = rcv_cnt_q;
        rcv_done_d = rcv_done_q;

        case (state_q)
            IDLE: begin
                if (bus.miss_detected) begin
                    base_d     = bus.miss_address & 16'hFFF0;
                    req_cnt_d  = 3'd0;
                    req_done_d = 1'b0;
                    rcv_cnt_d  = 3'd0;
                    rcv_done_d = 1'b0;
                    state_d    = FILL;
                end else begin
                    state_d    = IDLE;
                end
            end
            FILL: begin
                // Request issue runs independently of data return.
                if (!req_done_q) begin
                    req_cnt_d  = req_cnt_q + 3'd1;
                    req_done_d = (req_cnt_q == 3'd7);
                end else begin
                    req_cnt_d  = req_cnt_q;
                end
                if (accept_s) begin
                    rcv_cnt_d = rcv_cnt_q + 3'd1;
                    if (rcv_cnt_q == 3'd7) begin
                        rcv_done_d = 1'b1;
                        state_d    = TAG;
                    end else begin
                        state_d    = FILL;
                    end
                end else begin
                    rcv_cnt_d = rcv_cnt_q;
                end
            end
            TAG: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from next state so they come straight from flops.
        fsm_busy_d  = (state_d != IDLE);
        mem_read_d  = (state_d == FILL) && !req_done_d;
        write_tag_d = (state_d == TAG);
        if (mem_read_d) begin
            mem_address_d = base_d | {12'h000, req_cnt_d, 1'b0};
        end else begin
            mem_address_d = 16'h0000;
        end
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            base_q        <= 16'h0000;
            req_cnt_q     <= 3'd0;
            req_done_q    <= 1'b0;
            rcv_cnt_q     <= 3'd0;
            rcv_done_q    <= 1'b0;
            fsm_busy_q    <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_address_q <= 16'h0000;
            write_tag_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            req_cnt_q     <= req_cnt_d;
            req_done_q    <= req_done_d;
            rcv_cnt_q     <= rcv_cnt_d;
            rcv_done_q    <= rcv_done_d;
            fsm_busy_q    <= fsm_busy_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            write_tag_q   <= write_tag_d;
        end
    end

    assign bus.fsm_busy         = fsm_busy_q;
    assign bus.mem_read         = mem_read_q;
    assign bus.mem_address      = mem_address_q;
    assign bus.write_tag_array  = write_tag_q;
    assign bus.write_data_array = accept_s;
    assign bus.word_enable      = word_enable_s;
    assign bus.fill_data        = bus.mem_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a memory model with configurable
// latency and gaps answers requests, and a transaction-level reference
// (requests issued / words received per fill) predicts every output.
module tb_cache_fill_fsm;

    logic clk = 1'b0;
    logic rst;
    cache_fill_if bus ();

    cache_fill_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rdy;
        logic [15:0] d;
    } rsp_t;

    rsp_t        rsp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    // reference model of one fill
    bit          m_busy = 1'b0;
    bit          m_tag = 1'b0;
    logic [15:0] m_base = 16'h0000;
    int          m_issued = 0;
    int          m_received = 0;

    // memory model configuration
    int          lat = 4;
    int          gap_word = 99;
    int          gap_len = 0;
    int          cum_gap = 0;
    int          push_idx = 0;
    bit          rand_gaps = 1'b0;
    bit          force_stray = 1'b0;
    logic [15:0] data_base = 16'h0000;

    int          busy_cnt = 0;
    int          req_seen = 0;
    logic [15:0] last_req = 16'h0000;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance
    // the edge, update the reference and check registered outputs.
    task automatic step(input bit miss, input logic [15:0] maddr, input bit r);
        bit          v;
        logic [15:0] d;
        bit          exp_wr;
        bit          exp_rd;
        v = 1'b0;
        d = 16'($urandom);
        if (rsp_q.size() > 0 && rsp_q[0].rdy <= cyc) begin
            v = 1'b1;
            d = rsp_q[0].d;
            void'(rsp_q.pop_front());
        end else if (rsp_q.size() == 0 && (!m_busy || m_tag) &&
                     (force_stray || $urandom_range(0, 3) == 0)) begin
            v = 1'b1;
        end
        rst                = r;
        bus.miss_detected  = miss;
        bus.miss_address   = maddr;
        bus.mem_data_valid = v;
        bus.mem_data       = d;
        #1;
        exp_wr = m_busy && !m_tag && v;
        check_eq("write_data_array", {15'd0, bus.write_data_array}, {15'd0, exp_wr});
        check_eq("word_enable", {8'd0, bus.word_enable},
                 exp_wr ? (16'd1 << m_received) : 16'd0);
        check_eq("fill_data", bus.fill_data, d);
        if (bus.mem_read === 1'b1) begin
            if (push_idx == gap_word) cum_gap += gap_len;
            if (rand_gaps && $urandom_range(0, 3) == 0) cum_gap++;
            rsp_q.push_back('{rdy: cyc + lat + cum_gap, d: data_base + 16'(push_idx)});
            push_idx++;
            req_seen++;
            last_req = bus.mem_address;
        end
        @(posedge clk);
        cyc++;
        if (r) begin
            m_busy = 1'b0;
            m_tag  = 1'b0;
        end else if (m_tag) begin
            m_tag  = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_issued < 8) m_issued++;
            if (v) begin
                m_received++;
                if (m_received == 8) m_tag = 1'b1;
            end
        end else if (miss) begin
            m_busy     = 1'b1;
            m_base     = maddr & 16'hFFF0;
            m_issued   = 0;
            m_received = 0;
        end
        #1;
        exp_rd = m_busy && !m_tag && (m_issued < 8);
        check_eq("fsm_busy", {15'd0, bus.fsm_busy}, {15'd0, m_busy});
        check_eq("mem_read", {15'd0, bus.mem_read}, {15'd0, exp_rd});
        check_eq("write_tag_array", {15'd0, bus.write_tag_array}, {15'd0, m_tag});
        if (exp_rd) begin
            check_eq("mem_address", bus.mem_address, m_base + 16'(2 * m_issued));
        end else if (!m_busy) begin
            check_eq("mem_address_idle", bus.mem_address, 16'h0000);
        end
        if (bus.fsm_busy === 1'b1) busy_cnt++;
    endtask

    // Run one miss: optional second miss while busy and optional reset.
    task automatic run_fill(input logic [15:0] addr, input int l, input int gw, input int gl,
                            input int rst_at, input int miss2_at, input logic [15:0] m2_addr,
                            input logic [15:0] dbase, input bit rg);
        int c;
        int bound;
        bound = 0;
        while (rsp_q.size() > 0 && bound < 100) begin
            step(1'b0, 16'h0000, 1'b0);
            bound++;
        end
        lat       = l;
        gap_word  = gw;
        gap_len   = gl;
        cum_gap   = 0;
        push_idx  = 0;
        rand_gaps = rg;
        data_base = dbase;
        busy_cnt  = 0;
        req_seen  = 0;
        step(1'b1, addr, 1'b0);
        c = 1;
        while (m_busy && c < 200) begin
            step(c == miss2_at, (c == miss2_at) ? m2_addr : 16'h0000, c == rst_at);
            c++;
        end
        if (c >= 200) check_eq("fill_timeout", 16'd1, 16'd0);
        if (rst_at < 0) begin
            check_eq("busy_cycles", 16'(busy_cnt), 16'(9 + l + cum_gap));
            check_eq("request_count", 16'(req_seen), 16'd8);
            check_eq("last_request", last_req, (addr & 16'hFFF0) + 16'h000E);
        end
    endtask

    initial begin
        rst                = 1'b1;
        bus.miss_detected  = 1'b0;
        bus.miss_address   = 16'h0000;
        bus.mem_data_valid = 1'b0;
        bus.mem_data       = 16'h0000;
        @(posedge clk);
        #1;
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b0);

        // basic fill, latency 4
        run_fill(16'h1236, 4, 99, 0, -1, -1, 16'h0000, 16'hA000, 1'b0);
        // three-cycle gap between words 3 and 4
        run_fill(16'h1236, 4, 4, 3, -1, -1, 16'h0000, 16'hB000, 1'b0);
        // second miss while busy is ignored
        run_fill(16'h1236, 4, 99, 0, -1, 3, 16'h4000, 16'hC000, 1'b0);
        // stray valids in idle
        force_stray = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b0);
        force_stray = 1'b0;
        // reset mid-fill, then a clean fill of the top block
        run_fill(16'h1236, 4, 99, 0, 6, -1, 16'h0000, 16'hD000, 1'b0);
        run_fill(16'hFFF2, 4, 99, 0, -1, -1, 16'h0000, 16'hE000, 1'b0);
        // top-of-memory block
        run_fill(16'hFFFE, 3, 99, 0, -1, -1, 16'h0000, 16'hF000, 1'b0);

        // randomized fills
        for (int n = 0; n < 40; n++) begin
            int ra;
            int m2;
            ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 14)) : -1;
            m2 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1;
            run_fill(16'($urandom), $urandom_range(1, 6), 99, 0, ra, m2,
                     16'($urandom), 16'($urandom), 1'b1);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) step(1'b0, 16'h0000, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller that sits directly upstream of the cache data array. On a miss it issues eight pipelined word reads to main memory for the 16-byte block containing the missing address. It steers each returning word into the data array with a one-hot word enable and write strobe, then pulses a tag-array write to validate the block. Set/way selection (block enable) is decoded elsewhere from the same miss address.

## Interface
- None: widths are fixed by the 16-bit ISA: 16-bit addresses and data, 8 words per block, word-addressed in bytes.

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- miss_detected  in  1  cache lookup missed this cycle; sampled only in IDLE
- miss_address  in  16  byte address of the miss; sampled with miss_detected
- fsm_busy  out  1  fill in progress; stalls the pipeline
- mem_read  out  1  memory read request this cycle
- mem_address  out  16  byte address of the current request
- mem_data_valid  in  1  memory returns one word this cycle, in request order
- mem_data  in  16  returned word
- write_data_array  out  1  write strobe to data array
- word_enable  out  8  one-hot word select to data array
- fill_data  out  16  word to write (combinational pass of mem_data)
- write_tag_array  out  1  one-cycle tag/valid write strobe

## Operation
- States: IDLE, FILL, TAG.
- IDLE:
  - All outputs low; word_enable = 8'h00.
  - miss_detected=1 at an edge latches base = {miss_address[15:4], 4'h0}, clears req_cnt and rcv_cnt (3-bit counters plus a done flag each), and moves to FILL.
- FILL:
  - While fewer than 8 requests have been issued: mem_read=1 and mem_address = base | {req_cnt, 1'b0}; req_cnt increments each cycle. This gives 8 back-to-back requests at offsets 0x0,0x2,…,0xE, then mem_read=0.
  - Each cycle with mem_data_valid=1: write_data_array=1, word_enable = 1<<rcv_cnt, fill_data = mem_data; rcv_cnt increments.
  - When the 8th word is accepted, next state is TAG.
- TAG: write_tag_array=1 for exactly one cycle, then IDLE.
- fsm_busy=1 in FILL and TAG.
- Boundary rules:
  - miss_detected while busy is ignored.
  - mem_data_valid in IDLE or TAG is ignored: no write, counters unchanged.
  - Request issue and data return may overlap in the same cycle; both counters advance independently.
  - Valids may arrive with gaps; the FSM simply waits in FILL.
  - The address offset never wraps past the block: the upper 12 bits stay at base.
  - rst in any state forces IDLE, clears both counters, and drops all outputs the next cycle. Words in flight from an aborted fill are then ignored per the IDLE rule.
- Reset values: fsm_busy=0, mem_read=0, mem_address=16'h0000, write_data_array=0, word_enable=8'h00, write_tag_array=0. fill_data follows mem_data.

## Timing
- Outputs mem_read, mem_address, fsm_busy, and write_tag_array are decoded from registered state and counters, with no combinational path from miss_detected.
- write_data_array, word_enable, and fill_data are combinational from mem_data_valid and mem_data in FILL. The data array captures the word on the same edge.
- Miss at edge N:
  - FILL and fsm_busy from cycle N+1.
  - Requests in cycles N+1..N+8.
- Memory with latency L returns words in cycles N+1+L..N+8+L.
- TAG is the cycle after the last valid, then IDLE. Total busy = 8+L+1 cycles for gap-free returns.
- Next miss may be accepted on the first IDLE cycle.

## Test plan
- Basic fill, L=4:
  - Stimulus: miss_address=16'h1236 at edge 0; memory returns 16'hA000+k for word k.
  - Required response:
    - Requests to 0x1230…0x123E in cycles 1–8.
    - Writes with word_enable 01,02,…,80 in cycles 5–12 carrying A000…A007.
    - write_tag_array in cycle 13 only.
    - fsm_busy high cycles 1–13.
- Gapped returns: valid deasserted for 3 cycles between words 3 and 4 -> word_enable skips nothing (word 4 gets 8'h10), tag write delayed by 3 cycles.
- Miss while busy: second miss_detected with address 16'h4000 in cycle 3 -> no effect; requests stay in block 0x1230.
- Stray valid in IDLE: mem_data_valid=1 with no miss -> write_data_array=0, word_enable=00, no state change.
- Reset mid-fill: rst in cycle 6 of a fill -> cycle 7 IDLE with all outputs 0. The remaining valids produce no writes. A new miss at 0xFFF2 then fills 0xFFF0…0xFFFE correctly from word 0.
- Top-of-memory block: miss at 16'hFFFE -> last request address 16'hFFFE, no wrap to 0x0000.
